// File: rtl/decode_rv_if.sv
// Handshake and writeback bundle between fetch, decode and the ALU/writeback stage.
// The slave modport is the decode side; the master modport is the surrounding pipeline.
interface decode_rv_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        register_type_alu;
    logic        immediate_type_alu;
    logic        out_illegal;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_value;

    modport slave (
        input  in_valid, in_instruction, in_pc, out_ready, wb_valid, wb_rd, wb_value,
        output in_ready, out_valid, out_instruction, out_pc, register_type_alu,
               immediate_type_alu, out_illegal, rs1_value, rs2_value
    );

    modport master (
        output in_valid, in_instruction, in_pc, out_ready, wb_valid, wb_rd, wb_value,
        input  in_ready, out_valid, out_instruction, out_pc, register_type_alu,
               immediate_type_alu, out_illegal, rs1_value, rs2_value
    );
endinterface

// File: rtl/decode_rv.sv
// RV32I ALU decode stage: register file with writeback bypass, RAW scoreboard
// and a single registered output slot with valid/ready flow control.
module decode_rv #(
    parameter bit SCOREBOARD_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    decode_rv_if.slave  bus
);
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    logic [31:0] regs_reg [32];
    logic [31:0] pending_reg;
    logic [31:0] pending_next;

    logic        out_valid_reg;
    logic [31:0] out_instruction_reg;
    logic [31:0] out_pc_reg;
    logic        r_type_reg;
    logic        i_type_reg;
    logic        illegal_reg;
    logic [31:0] rs1_value_reg;
    logic [31:0] rs2_value_reg;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        is_r;
    logic        is_i;
    logic        is_alu;
    logic        bypass1;
    logic        bypass2;
    logic [31:0] read1;
    logic [31:0] read2;
    logic        hazard;
    logic        ready;
    logic        accept;

    assign opcode = bus.in_instruction[6:0];
    assign rd     = bus.in_instruction[11:7];
    assign rs1    = bus.in_instruction[19:15];
    assign rs2    = bus.in_instruction[24:20];
    assign is_r   = (opcode == OP_R);
    assign is_i   = (opcode == OP_I);
    assign is_alu = is_r || is_i;

    // Writeback in the same cycle forwards straight into the operand read.
    assign bypass1 = bus.wb_valid && (bus.wb_rd == rs1) && (rs1 != 5'd0);
    assign bypass2 = bus.wb_valid && (bus.wb_rd == rs2) && (rs2 != 5'd0);
    assign read1   = (rs1 == 5'd0) ? 32'd0 : (bypass1 ? bus.wb_value : regs_reg[rs1]);
    assign read2   = (rs2 == 5'd0) ? 32'd0 : (bypass2 ? bus.wb_value : regs_reg[rs2]);

    assign hazard = SCOREBOARD_EN && bus.in_valid &&
                    ((is_alu && pending_reg[rs1] && !bypass1) ||
                     (is_r   && pending_reg[rs2] && !bypass2));

    // reset_n gates ready so nothing is taken while reset is held.
    assign ready  = reset_n && (!out_valid_reg || bus.out_ready) && !hazard;
    assign accept = bus.in_valid && ready;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_regfile
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    regs_reg[gi] <= '0;
                end else if (gi != 0 && bus.wb_valid && bus.wb_rd == 5'(gi)) begin
                    regs_reg[gi] <= bus.wb_value;
                end
            end
        end
    endgenerate

    // Clear first, then set, so a same-cycle set on the same register wins.
    always_comb begin
        pending_next = pending_reg;
        if (bus.wb_valid) begin
            pending_next[bus.wb_rd] = 1'b0;
        end
        if (accept && is_alu && rd != 5'd0) begin
            pending_next[rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_reg       <= 1'b0;
            out_instruction_reg <= '0;
            out_pc_reg          <= '0;
            r_type_reg          <= 1'b0;
            i_type_reg          <= 1'b0;
            illegal_reg         <= 1'b0;
            rs1_value_reg       <= '0;
            rs2_value_reg       <= '0;
        end else if (accept) begin
            out_valid_reg       <= 1'b1;
            out_instruction_reg <= bus.in_instruction;
            out_pc_reg          <= bus.in_pc;
            r_type_reg          <= is_r;
            i_type_reg          <= is_i;
            illegal_reg         <= !is_alu;
            rs1_value_reg       <= is_alu ? read1 : 32'd0;
            rs2_value_reg       <= is_r ? read2 : 32'd0;
        end else if (bus.out_ready) begin
            out_valid_reg       <= 1'b0;
        end
    end

    assign bus.in_ready           = ready;
    assign bus.out_valid          = out_valid_reg;
    assign bus.out_instruction    = out_instruction_reg;
    assign bus.out_pc             = out_pc_reg;
    assign bus.register_type_alu  = r_type_reg;
    assign bus.immediate_type_alu = i_type_reg;
    assign bus.out_illegal        = illegal_reg;
    assign bus.rs1_value          = rs1_value_reg;
    assign bus.rs2_value          = rs2_value_reg;
endmodule

// File: tb/tb_decode_rv.sv
// Scoreboard bench for decode_rv: directed scenarios then random traffic,
// checked against an architectural register/pending model.
module tb_decode_rv;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    decode_rv_if bus ();

    decode_rv #(.SCOREBOARD_EN(1'b1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic        r;
        logic        i;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_ov;
    int          n_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 32; k++) begin
            m_regs[k] = 32'd0;
            m_pend[k] = 1'b0;
        end
        m_ov = 1'b0;
        q.delete();
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (bus.wb_valid && bus.wb_rd == r) return bus.wb_value;
        return m_regs[r];
    endfunction

    // Called just after a rising edge; returns just after the next rising edge.
    task automatic drive(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                         input bit ordy, input bit wv, input logic [4:0] wrd,
                         input logic [31:0] wval);
        bit   r_t, i_t, stall, exp_ready;
        logic [4:0] s1, s2, d;
        exp_t e;
        bus.in_valid = iv; bus.in_instruction = ins; bus.in_pc = pc;
        bus.out_ready = ordy; bus.wb_valid = wv; bus.wb_rd = wrd; bus.wb_value = wval;
        @(negedge clock);
        #1;
        r_t = (ins[6:0] == 7'h33);
        i_t = (ins[6:0] == 7'h13);
        d = ins[11:7]; s1 = ins[19:15]; s2 = ins[24:20];
        // A source stalls when its write is outstanding and not arriving this cycle.
        stall = 1'b0;
        if ((r_t || i_t) && s1 != 0 && m_pend[s1] && !(wv && wrd == s1)) stall = 1'b1;
        if (r_t && s2 != 0 && m_pend[s2] && !(wv && wrd == s2)) stall = 1'b1;
        exp_ready = reset_n && (!m_ov || ordy) && !(iv && stall);
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
        if (reset_n) begin
            if (iv && exp_ready) begin
                e.instr = ins; e.pc = pc; e.r = r_t; e.i = i_t; e.ill = !(r_t || i_t);
                e.rs1v = (r_t || i_t) ? m_read(s1) : 32'd0;
                e.rs2v = r_t ? m_read(s2) : 32'd0;
                q.push_back(e);
                n_acc++;
            end
            if (wv) begin
                if (wrd != 0) m_regs[wrd] = wval;
                m_pend[wrd] = 1'b0;
            end
            if (iv && exp_ready && (r_t || i_t) && d != 0) m_pend[d] = 1'b1;
            if (iv && exp_ready) m_ov = 1'b1;
            else if (ordy) m_ov = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    // Monitor: compares the presented output with the oldest expected entry.
    always @(negedge clock) begin
        checks++;
        if (bus.out_valid !== (q.size() != 0)) begin
            failures++;
            $display("FAIL out_valid: got %0b expected %0b", bus.out_valid, q.size() != 0);
        end else if (bus.out_valid) begin
            checks++;
            if (bus.out_instruction !== q[0].instr || bus.out_pc !== q[0].pc ||
                bus.rs1_value !== q[0].rs1v || bus.rs2_value !== q[0].rs2v ||
                bus.register_type_alu !== q[0].r || bus.immediate_type_alu !== q[0].i ||
                bus.out_illegal !== q[0].ill) begin
                failures++;
                $display("FAIL out: got ins=%08h pc=%08h rs1=%08h rs2=%08h r=%0b i=%0b ill=%0b expected ins=%08h pc=%08h rs1=%08h rs2=%08h r=%0b i=%0b ill=%0b",
                    bus.out_instruction, bus.out_pc, bus.rs1_value, bus.rs2_value,
                    bus.register_type_alu, bus.immediate_type_alu, bus.out_illegal,
                    q[0].instr, q[0].pc, q[0].rs1v, q[0].rs2v, q[0].r, q[0].i, q[0].ill);
            end
            if (bus.out_ready) void'(q.pop_front());
        end
    end

    function automatic logic [31:0] mk_instr(input int kind, input logic [4:0] d,
                                             input logic [4:0] s1, input logic [4:0] s2);
        logic [6:0] bad [7];
        logic [31:0] w;
        bad = '{7'h73, 7'h37, 7'h17, 7'h6F, 7'h03, 7'h23, 7'h63};
        w = $urandom;
        case (kind)
            0: return {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, s2, s1, w[14:12], d, 7'h33};
            1: return {w[31:20], s1, w[14:12], d, 7'h13};
            default: return {w[31:7], bad[$urandom_range(0, 6)]};
        endcase
    endfunction

    initial begin
        logic [4:0] rr;
        bus.in_valid = 0; bus.in_instruction = 0; bus.in_pc = 0; bus.out_ready = 0;
        bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_value = 0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("reset rs1_value", bus.rs1_value, 32'd0);
        reset_n = 1'b1;

        drive(1, 32'h00500093, 32'h100, 1, 0, 0, 0);          // addi x1,x0,5
        chk("addi pending stalls add", 32'(m_pend[1]), 32'd1);
        drive(1, 32'h00108133, 32'h104, 1, 0, 0, 0);          // add x2,x1,x1 stalls
        drive(1, 32'h00108133, 32'h104, 1, 0, 0, 0);
        drive(1, 32'h00108133, 32'h104, 1, 1, 1, 5);          // bypassed writeback
        drive(0, 32'h0, 32'h0, 1, 1, 0, 32'hDEADBEEF);        // write to x0 ignored
        drive(1, 32'h000001B3, 32'h108, 1, 1, 2, 32'h11);     // add x3,x0,x0
        drive(1, 32'h00108213, 32'h10C, 0, 1, 3, 32'h22);     // addi x4,x1,1
        for (int k = 0; k < 3; k++) drive(1, 32'h00000073, 32'h110, 0, 0, 0, 0);
        drive(1, 32'h00000073, 32'h110, 1, 1, 4, 32'h6);      // ecall
        drive(1, 32'h00100093, 32'h114, 1, 0, 0, 0);          // addi x1,x0,1
        chk("pre-reset out_valid", {31'd0, bus.out_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async out_instruction", bus.out_instruction, 32'd0);
        chk("async rs1_value", bus.rs1_value, 32'd0);
        model_clear();
        drive(1, 32'h00108133, 32'h200, 1, 0, 0, 0);
        reset_n = 1'b1;
        drive(1, 32'h00108133, 32'h204, 1, 0, 0, 0);          // no stale pending

        for (int n = 0; n < 1500; n++) begin
            rr = 5'($urandom_range(0, 7));
            drive($urandom_range(0, 3) != 0,
                  mk_instr($urandom_range(0, 4), 5'($urandom_range(0, 7)),
                           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))),
                  $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) != 0, rr, $urandom);
        end
        for (int k = 0; k < 4; k++) drive(0, 32'h0, 32'h0, 1, 0, 0, 0);
        chk("queue drained", 32'(q.size()), 32'd0);
        checks++;
        if (n_acc < 200) begin
            failures++;
            $display("FAIL throughput: got %0d accepts expected at least 200", n_acc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decode_rv.md
DECODE_RV -- requirements
Module: decode_rv

Interface
REQ-001 Parameter SCOREBOARD_EN, default 1, meaning: 1 enables RAW hazard stalling; 0 never stalls on pending registers.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  fetch presents an instruction.
REQ-005 in_ready  output  1  decode accepts the instruction this cycle.
REQ-006 in_instruction  input  32  raw RV32I instruction word.
REQ-007 in_pc  input  32  PC of in_instruction.
REQ-008 out_valid  output  1  decoded instruction available to the ALU stage.
REQ-009 out_ready  input  1  ALU stage consumes the output this cycle.
REQ-010 out_instruction  output  32  registered instruction word.
REQ-011 out_pc  output  32  registered PC.
REQ-012 register_type_alu  output  1  opcode 7'b0110011 (R-type ALU).
REQ-013 immediate_type_alu  output  1  opcode 7'b0010011 (I-type ALU).
REQ-014 out_illegal  output  1  opcode is neither ALU type.
REQ-015 rs1_value  output  32  operand value of instruction[19:15].
REQ-016 rs2_value  output  32  operand value of instruction[24:20].
REQ-017 wb_valid  input  1  writeback strobe from the ALU/writeback stage.
REQ-018 wb_rd  input  5  writeback destination register.
REQ-019 wb_value  input  32  writeback data (ALU rd_result).

Function
REQ-020 Block SHALL contain a 32x32 register file; x0 reads 0, writes to x0 ignored.
REQ-021 Register file write SHALL occur on the rising edge when wb_valid=1 and wb_rd!=0.
REQ-022 Operand read SHALL bypass: if wb_valid=1 and wb_rd equals the source index (nonzero), wb_value is used in the same cycle.
REQ-023 Scoreboard: 32 pending bits; bit 0 always 0.
REQ-024 On accept of an ALU-type instruction with rd!=0, pending[rd] SHALL set; wb_valid clears pending[wb_rd].
REQ-025 Simultaneous set and clear of the same bit: set wins.
REQ-026 hazard = SCOREBOARD_EN && in_valid && ((rs1 used && pending[rs1] && !bypass1) || (R-type && pending[rs2] && !bypass2)); rs1 used for both ALU types.
REQ-027 in_ready SHALL equal (!out_valid || out_ready) && !hazard.
REQ-028 Accept (in_valid && in_ready) SHALL load all out_* registers next edge; latency exactly 1 cycle; out_valid=1.
REQ-029 rs2_value for I-type SHALL be 0.
REQ-030 out_valid && !out_ready SHALL hold every output stable.
REQ-031 out_ready with no accept SHALL clear out_valid next edge.
REQ-032 Illegal opcodes SHALL be accepted, out_illegal=1, both type flags 0, operands 0, no scoreboard set.
REQ-033 Back-to-back accepts SHALL sustain one instruction per cycle absent hazards.

Reset
REQ-034 reset_n low SHALL immediately clear out_valid, all out_* data, type flags, out_illegal, all pending bits, and all registers to 0.
REQ-035 in_ready SHALL be 0 while reset_n is low; in-flight instructions are dropped; first accept possible on the first edge after deassertion.

Verification
REQ-036 Reset then in 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, immediate_type_alu=1, rs1_value=0, pending[1]=1.
REQ-037 Then in 0x00108133 (add x2,x1,x1) with no writeback -> in_ready=0 held; wb_valid=1,wb_rd=1,wb_value=5 -> accepted same cycle, rs1_value=rs2_value=5.
REQ-038 wb_valid=1, wb_rd=0, wb_value=0xDEADBEEF, then read x0 -> rs1_value=0.
REQ-039 out_ready=0 for 3 cycles with out_valid=1 -> outputs unchanged, in_ready=0; out_ready=1 -> next instruction loads.
REQ-040 in 0x00000073 (ecall) -> out_illegal=1, flags 0, no pending bit set.
REQ-041 Assert reset_n=0 mid-stream with out_valid=1 and pending[1]=1 -> out_valid=0 and pending cleared without a clock edge.
